// File: rtl/l15_req_arbiter.sv
// Two-requester round-robin arbiter feeding the single L1.5 request port.
// Atomic pairs lock the grant to their owner so both halves reach the L1.5 back to back.
module l15_req_arbiter #(
    parameter int PAYLOAD_W = 180
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_val,
    input  logic                 req0_atomic,
    input  logic [PAYLOAD_W-1:0] req0_payload,
    output logic                 req0_rdy,
    input  logic                 req1_val,
    input  logic                 req1_atomic,
    input  logic [PAYLOAD_W-1:0] req1_payload,
    output logic                 req1_rdy,
    output logic                 arb_l15_val,
    output logic [PAYLOAD_W-1:0] arb_l15_payload,
    output logic                 arb_l15_src,
    input  logic                 l15_arb_ack,
    output logic                 arb_locked
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY      = 2'd1,
        LOCK_WAIT = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic                   out_val, out_val_nxt;
    logic                   out_src, out_src_nxt;
    logic [PAYLOAD_W-1:0]   out_payload, out_payload_nxt;
    logic                   rr_ptr, rr_ptr_nxt;
    logic                   lock_owner, lock_owner_nxt;

    logic                   free;
    logic                   sel0, sel1;
    logic                   cap_atomic;

    assign free = !out_val || l15_arb_ack;

    // Grant depends only on valids and arbitration state, never on payload.
    always_comb begin
        sel0 = 1'b0;
        sel1 = 1'b0;
        if (!rst && free) begin
            if (state == LOCK_WAIT) begin
                sel0 = !lock_owner && req0_val;
                sel1 =  lock_owner && req1_val;
            end else if (req0_val && req1_val) begin
                sel0 = !rr_ptr;
                sel1 =  rr_ptr;
            end else begin
                sel0 = req0_val;
                sel1 = req1_val;
            end
        end
    end

    assign req0_rdy   = sel0;
    assign req1_rdy   = sel1;
    assign cap_atomic = sel1 ? req1_atomic : req0_atomic;

    always_comb begin
        state_nxt       = state;
        out_val_nxt     = out_val;
        out_src_nxt     = out_src;
        out_payload_nxt = out_payload;
        rr_ptr_nxt      = rr_ptr;
        lock_owner_nxt  = lock_owner;
        if (sel0 || sel1) begin
            out_val_nxt     = 1'b1;
            out_src_nxt     = sel1;
            out_payload_nxt = sel1 ? req1_payload : req0_payload;
            if (state == LOCK_WAIT) begin
                // Second half of the pair: the atomic bit here is don't-care.
                state_nxt  = BUSY;
                rr_ptr_nxt = !lock_owner;
            end else if (cap_atomic) begin
                state_nxt      = LOCK_WAIT;
                lock_owner_nxt = sel1;
            end else begin
                state_nxt  = BUSY;
                rr_ptr_nxt = !sel1;
            end
        end else if (out_val && l15_arb_ack) begin
            out_val_nxt = 1'b0;
            if (state != LOCK_WAIT) begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            out_val     <= 1'b0;
            out_src     <= 1'b0;
            out_payload <= '0;
            rr_ptr      <= 1'b0;
            lock_owner  <= 1'b0;
        end else begin
            state       <= state_nxt;
            out_val     <= out_val_nxt;
            out_src     <= out_src_nxt;
            out_payload <= out_payload_nxt;
            rr_ptr      <= rr_ptr_nxt;
            lock_owner  <= lock_owner_nxt;
        end
    end

    assign arb_l15_val     = out_val;
    assign arb_l15_payload = out_payload;
    assign arb_l15_src     = out_src;
    assign arb_locked      = (state == LOCK_WAIT);

endmodule

// File: tb/tb_l15_req_arbiter.sv
// Directed bench for l15_req_arbiter: reset, single request, round-robin,
// backpressure, atomic lock, reset mid-lock and stray ack.
module tb_l15_req_arbiter;

    localparam int PW = 180;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_val, req0_atomic, req0_rdy;
    logic [PW-1:0] req0_payload;
    logic          req1_val, req1_atomic, req1_rdy;
    logic [PW-1:0] req1_payload;
    logic          arb_l15_val, arb_l15_src, l15_arb_ack, arb_locked;
    logic [PW-1:0] arb_l15_payload;

    int total = 0;
    int bad   = 0;

    l15_req_arbiter #(.PAYLOAD_W(PW)) dut (
        .clk             (clk),
        .rst             (rst),
        .req0_val        (req0_val),
        .req0_atomic     (req0_atomic),
        .req0_payload    (req0_payload),
        .req0_rdy        (req0_rdy),
        .req1_val        (req1_val),
        .req1_atomic     (req1_atomic),
        .req1_payload    (req1_payload),
        .req1_rdy        (req1_rdy),
        .arb_l15_val     (arb_l15_val),
        .arb_l15_payload (arb_l15_payload),
        .arb_l15_src     (arb_l15_src),
        .l15_arb_ack     (l15_arb_ack),
        .arb_locked      (arb_locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    int c0, c1;
    logic exp_src;
    logic [PW-1:0] held;

    initial begin
        rst = 1'b1;
        req0_val = 1'b1; req0_atomic = 1'b0; req0_payload = '0;
        req1_val = 1'b0; req1_atomic = 1'b0; req1_payload = '0;
        l15_arb_ack = 1'b0;
        step();
        settle();
        chk("rst_val",    PW'(arb_l15_val), PW'(0));
        chk("rst_src",    PW'(arb_l15_src), PW'(0));
        chk("rst_pay",    arb_l15_payload,  PW'(0));
        chk("rst_lock",   PW'(arb_locked),  PW'(0));
        chk("rst_rdy0",   PW'(req0_rdy),    PW'(0));
        req0_val = 1'b0;
        #2 rst = 1'b0;

        // Single request
        step();
        req0_val = 1'b1; req0_payload = PW'('hA5);
        settle();
        chk("single_rdy0", PW'(req0_rdy), PW'(1));
        chk("single_rdy1", PW'(req1_rdy), PW'(0));
        step();
        req0_val = 1'b0;
        chk("single_val", PW'(arb_l15_val), PW'(1));
        chk("single_pay", arb_l15_payload,  PW'('hA5));
        chk("single_src", PW'(arb_l15_src), PW'(0));
        step();
        step();
        chk("single_hold", PW'(arb_l15_val), PW'(1));
        l15_arb_ack = 1'b1;
        step();
        l15_arb_ack = 1'b0;
        chk("single_ackd", PW'(arb_l15_val), PW'(0));

        // Stray ack while idle
        l15_arb_ack = 1'b1;
        step();
        l15_arb_ack = 1'b0;
        chk("stray_val",  PW'(arb_l15_val), PW'(0));
        chk("stray_lock", PW'(arb_locked),  PW'(0));
        chk("stray_pay",  arb_l15_payload,  PW'('hA5));

        // Round-robin: last capture was req0, so req1 wins the first tie.
        c0 = 0; c1 = 0;
        l15_arb_ack = 1'b1;
        req0_val = 1'b1; req1_val = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req0_payload = PW'(32'h100 + c0);
            req1_payload = PW'(32'h200 + c1);
            settle();
            exp_src = (i % 2 == 0);
            chk("rr_rdy0", PW'(req0_rdy), PW'(!exp_src));
            chk("rr_rdy1", PW'(req1_rdy), PW'(exp_src));
            step();
            chk("rr_val", PW'(arb_l15_val), PW'(1));
            chk("rr_src", PW'(arb_l15_src), PW'(exp_src));
            chk("rr_pay", arb_l15_payload, exp_src ? PW'(32'h200 + c1) : PW'(32'h100 + c0));
            if (exp_src) c1++; else c0++;
        end
        req0_val = 1'b0; req1_val = 1'b0;
        step();
        chk("rr_drain", PW'(arb_l15_val), PW'(0));

        // Backpressure: rr_ptr=1 after the last req0 capture.
        l15_arb_ack = 1'b0;
        req0_val = 1'b1; req1_val = 1'b1;
        req0_payload = PW'('h0B0); req1_payload = PW'('h1B1);
        settle();
        chk("bp_rdy1", PW'(req1_rdy), PW'(1));
        step();
        held = arb_l15_payload;
        chk("bp_cap", held, PW'('h1B1));
        req1_payload = PW'('h1B2);
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("bp_rdy0", PW'(req0_rdy), PW'(0));
            chk("bp_rdy1", PW'(req1_rdy), PW'(0));
            chk("bp_pay",  arb_l15_payload, PW'('h1B1));
            chk("bp_val",  PW'(arb_l15_val), PW'(1));
            step();
        end
        l15_arb_ack = 1'b1;
        settle();
        chk("bp_next_rdy0", PW'(req0_rdy), PW'(1));
        chk("bp_next_rdy1", PW'(req1_rdy), PW'(0));
        step();
        chk("bp_next_src", PW'(arb_l15_src), PW'(0));
        chk("bp_next_pay", arb_l15_payload,  PW'('h0B0));
        chk("bp_next_val", PW'(arb_l15_val), PW'(1));
        req0_val = 1'b0; req1_val = 1'b0;
        step();
        chk("bp_drain", PW'(arb_l15_val), PW'(0));

        // Atomic: req1 sends P1 (atomic) then P2; req0 valid throughout.
        req0_val = 1'b1; req0_payload = PW'('h0AA);
        req1_val = 1'b1; req1_atomic = 1'b1; req1_payload = PW'('h301);
        settle();
        chk("at_p1_rdy1", PW'(req1_rdy), PW'(1));
        step();
        chk("at_p1_src",  PW'(arb_l15_src), PW'(1));
        chk("at_p1_pay",  arb_l15_payload,  PW'('h301));
        chk("at_p1_lock", PW'(arb_locked),  PW'(1));
        // Owner not ready: req0 must still be blocked.
        req1_val = 1'b0; req1_atomic = 1'b0;
        settle();
        chk("at_gap_rdy0", PW'(req0_rdy), PW'(0));
        step();
        chk("at_gap_lock", PW'(arb_locked),  PW'(1));
        chk("at_gap_val",  PW'(arb_l15_val), PW'(0));
        chk("at_gap_rdy0b", PW'(req0_rdy),   PW'(0));
        req1_val = 1'b1; req1_payload = PW'('h302);
        settle();
        chk("at_p2_rdy1", PW'(req1_rdy), PW'(1));
        chk("at_p2_rdy0", PW'(req0_rdy), PW'(0));
        step();
        req1_val = 1'b0;
        chk("at_p2_src",  PW'(arb_l15_src), PW'(1));
        chk("at_p2_pay",  arb_l15_payload,  PW'('h302));
        chk("at_p2_lock", PW'(arb_locked),  PW'(0));
        settle();
        chk("at_r0_rdy0", PW'(req0_rdy), PW'(1));
        step();
        chk("at_r0_src", PW'(arb_l15_src), PW'(0));
        chk("at_r0_pay", arb_l15_payload,  PW'('h0AA));
        req0_val = 1'b0;
        step();

        // Reset mid-lock; rr_ptr=1 beforehand so req0's post-reset win shows the clear.
        req1_val = 1'b1; req1_atomic = 1'b1; req1_payload = PW'('h401);
        step();
        req1_atomic = 1'b0;
        req1_payload = PW'('h402);
        req1_val = 1'b0;
        l15_arb_ack = 1'b0;
        chk("rl_lock_pre", PW'(arb_locked),  PW'(1));
        chk("rl_val_pre",  PW'(arb_l15_val), PW'(1));
        rst = 1'b1;
        req1_val = 1'b1;
        settle();
        chk("rl_val",  PW'(arb_l15_val), PW'(0));
        chk("rl_lock", PW'(arb_locked),  PW'(0));
        chk("rl_rdy1", PW'(req1_rdy),    PW'(0));
        step();
        rst = 1'b0;
        req0_val = 1'b1; req0_payload = PW'('h0CC);
        settle();
        chk("rl_post_rdy0", PW'(req0_rdy), PW'(1));
        chk("rl_post_rdy1", PW'(req1_rdy), PW'(0));
        step();
        chk("rl_post_src", PW'(arb_l15_src), PW'(0));
        chk("rl_post_pay", arb_l15_payload,  PW'('h0CC));
        req0_val = 1'b0; req1_val = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
